// File: rtl/pe_link_pkg.sv
// pe_link_pkg: definitions shared by the PE link FIFO.
//   - default token field widths (tag / payload)
//   - token field offsets within {tag, ctrl, payload}
//   - tok_valid(): a token is valid when its tag is non-zero
// Optional feature macro used by pe_link_fifo: PE_LINK_FIFO_OVF_CNT_EN.
package pe_link_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 3;

    // Token layout (LSB first): payload, ctrl, tag.
    localparam int PAYLOAD_LSB = 0;

    function automatic int ctrl_pos(input int data_w);
        return data_w;
    endfunction

    function automatic int tag_lsb(input int data_w);
        return data_w + 1;
    endfunction

    // Tag is passed zero-extended to 32 bits so the helper works for any TAG_W.
    function automatic logic tok_valid(input logic [31:0] tag);
        return |tag;
    endfunction

endpackage

// File: rtl/pe_link_fifo.sv
// pe_link_fifo: first-word-fall-through token FIFO between PEs.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst_n    in   asynchronous active-low reset
//   data_w   in   upstream token {tag, ctrl, payload}; tag != 0 means valid
//   flush    in   synchronous clear of stored tokens, overflow flag and counter
//   r_en     in   downstream ready; pops the head token when not empty
//   data_r   out  head token (tag forced to 0 while empty)
//   bp       out  upstream ready: free slots exceed AF_MARGIN
//   count    out  current occupancy
//   ovf      out  sticky overflow flag
//   ovf_cnt  out  dropped-token counter (saturating), only when the macro
//                 PE_LINK_FIFO_OVF_CNT_EN is defined
//
// Parameters: DATA_W, TAG_W, DEPTH (power of 2, >= 2), AF_MARGIN (0..DEPTH-1).
module pe_link_fifo
    import pe_link_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TAG_W+1+DATA_W-1:0]     data_w,
    input  logic                          flush,
    input  logic                          r_en,
    output logic [TAG_W+1+DATA_W-1:0]     data_r,
    output logic                          bp,
    output logic [$clog2(DEPTH):0]        count,
`ifdef PE_LINK_FIFO_OVF_CNT_EN
    output logic [7:0]                    ovf_cnt,
`endif
    output logic                          ovf
);

    localparam int TOK_W = TAG_W + 1 + DATA_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int TLSB  = tag_lsb(DATA_W);

    logic [TOK_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf_q;

    logic wr_vld;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign wr_vld = tok_valid(32'(data_w[TLSB +: TAG_W]));
    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));

    // A pop frees the slot in the same edge, so a write while full is
    // accepted if the head leaves. Pop from empty is ignored, so a write
    // into an empty FIFO never bypasses storage.
    assign pop  = r_en && !empty;
    assign push = wr_vld && (!full || pop);
    assign drop = wr_vld && full && !pop;

    // Pointers, occupancy and overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
            if (drop) ovf_q <= 1'b1;
        end
    end

    // Storage has no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= data_w;
    end

`ifdef PE_LINK_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (flush) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    // Head token straight from storage; its tag is masked while empty so
    // downstream never sees a stale valid token.
    always_comb begin
        data_r = mem[rd_ptr];
        if (empty) data_r[TLSB +: TAG_W] = '0;
    end

    assign bp    = ((CW'(DEPTH) - cnt) > CW'(AF_MARGIN));
    assign count = cnt;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_pe_link_fifo.sv
module tb_pe_link_fifo;

    localparam int DW    = 32;
    localparam int TW    = 3;
    localparam int DEPTH = 4;
    localparam int AFM   = 1;
    localparam int TOKW  = TW + 1 + DW;
    localparam int CW    = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            flush = 1'b0;
    logic            r_en  = 1'b0;
    logic [TOKW-1:0] data_w = '0;
    logic [TOKW-1:0] data_r;
    logic            bp;
    logic            ovf;
    logic [CW-1:0]   count;
`ifdef PE_LINK_FIFO_OVF_CNT_EN
    logic [7:0]      ovf_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_link_fifo #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_w (data_w),
        .flush  (flush),
        .r_en   (r_en),
        .data_r (data_r),
        .bp     (bp),
        .count  (count),
`ifdef PE_LINK_FIFO_OVF_CNT_EN
        .ovf_cnt(ovf_cnt),
`endif
        .ovf    (ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of accepted tokens ----------
    logic [TOKW-1:0] mq[$];
    bit              m_ovf  = 1'b0;
    int              m_ocnt = 0;

    always @(posedge clk or negedge rst_n) begin
        bit v, p, was_full;
        if (!rst_n || flush) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_ocnt = 0;
        end else begin
            v        = (data_w[TOKW-1 -: TW] != '0);
            p        = r_en && (mq.size() > 0);
            was_full = (mq.size() == DEPTH);
            if (p) void'(mq.pop_front());
            if (v) begin
                if (!was_full || p) mq.push_back(data_w);
                else begin
                    m_ovf = 1'b1;
                    if (m_ocnt < 255) m_ocnt++;
                end
            end
        end
    end

    // Every falling edge the outputs are compared against the model.
    always @(negedge clk) begin
        chk("count", 64'(count), 64'(mq.size()));
        chk("bp", 64'(bp), 64'((DEPTH - mq.size()) > AFM));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        if (mq.size() == 0) chk("tag_empty", 64'(data_r[TOKW-1 -: TW]), 64'(0));
        else                chk("head", 64'(data_r), 64'(mq[0]));
`ifdef PE_LINK_FIFO_OVF_CNT_EN
        chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ocnt));
`endif
    end

    // ---------------- stimulus helpers --------------------------------------
    function automatic logic [TOKW-1:0] tok(input logic [TW-1:0] tg, input logic c,
                                            input logic [DW-1:0] pl);
        return {tg, c, pl};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_w = '0;
        r_en   = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic drain(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        logic [DW-1:0] ex [4];
        ex = '{e0, e1, e2, e3};
        data_w = '0;
        for (int k = 0; k < 4; k++) begin
            chk("drain_tag", 64'(data_r[TOKW-1 -: TW]), 64'(3'b110));
            chk("drain_payload", 64'(data_r[DW-1:0]), 64'(ex[k]));
            r_en = 1'b1;
            step();
        end
        idle();
        chk("drained_count", 64'(count), 64'(0));
    endtask

    initial begin
        // asynchronous reset, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_bp", 64'(bp), 64'(1));
        chk("rst_tag", 64'(data_r[TOKW-1 -: TW]), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        #1 rst_n = 1'b1;
        step();

        // fill 1..4, bp drops after the 3rd write
        for (int i = 1; i <= 4; i++) begin
            data_w = tok(3'b110, 1'b0, DW'(i));
            step();
            if (i == 2) chk("bp_after_2", 64'(bp), 64'(1));
            if (i == 3) chk("bp_after_3", 64'(bp), 64'(0));
        end
        chk("fill_count", 64'(count), 64'(4));
        chk("fill_ovf", 64'(ovf), 64'(0));

        // overflow: token 5 dropped
        data_w = tok(3'b110, 1'b0, 32'd5);
        step();
        idle();
        chk("ovf_set", 64'(ovf), 64'(1));
        chk("ovf_count", 64'(count), 64'(4));
`ifdef PE_LINK_FIFO_OVF_CNT_EN
        chk("ovf_cnt_1", 64'(ovf_cnt), 64'(1));
`endif
        drain(1, 2, 3, 4);
        chk("ovf_sticky", 64'(ovf), 64'(1));
        flush = 1'b1;
        step();
        idle();
        chk("flush_ovf", 64'(ovf), 64'(0));

        // write with pop while full
        for (int i = 1; i <= 4; i++) begin
            data_w = tok(3'b110, 1'b0, DW'(i));
            step();
        end
        data_w = tok(3'b110, 1'b0, 32'd9);
        r_en   = 1'b1;
        step();
        idle();
        chk("wp_full_count", 64'(count), 64'(4));
        chk("wp_full_ovf", 64'(ovf), 64'(0));
        drain(2, 3, 4, 9);

        // write with pop while empty: no bypass
        data_w = tok(3'b110, 1'b0, 32'd7);
        r_en   = 1'b1;
        step();
        idle();
        chk("we_tag", 64'(data_r[TOKW-1 -: TW]), 64'(3'b110));
        chk("we_payload", 64'(data_r[DW-1:0]), 64'(7));
        chk("we_count", 64'(count), 64'(1));
        r_en = 1'b1;
        step();
        idle();

        // tag=0 tokens are ignored
        for (int i = 0; i < 10; i++) begin
            data_w = tok(3'b000, i[0], 32'hA5A5_0000 + DW'(i));
            r_en   = i[1];
            step();
        end
        idle();
        chk("tag0_count", 64'(count), 64'(0));
        chk("tag0_tag", 64'(data_r[TOKW-1 -: TW]), 64'(0));

        // async reset mid-cycle with count=3
        for (int i = 0; i < 3; i++) begin
            data_w = tok(3'b101, 1'b1, 32'h100 + DW'(i));
            step();
        end
        idle();
        chk("pre_rst_count", 64'(count), 64'(3));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'(0));
        chk("mid_rst_bp", 64'(bp), 64'(1));
        chk("mid_rst_tag", 64'(data_r[TOKW-1 -: TW]), 64'(0));
        rst_n = 1'b1;
        step();

        // flush with count=2; a write in the flush cycle is discarded
        for (int i = 0; i < 2; i++) begin
            data_w = tok(3'b011, 1'b0, 32'h200 + DW'(i));
            step();
        end
        chk("pre_flush_count", 64'(count), 64'(2));
        data_w = tok(3'b011, 1'b0, 32'h2FF);
        r_en   = 1'b1;
        flush  = 1'b1;
        step();
        idle();
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_bp", 64'(bp), 64'(1));
        chk("flush_tag", 64'(data_r[TOKW-1 -: TW]), 64'(0));

        // mixed traffic: pointer wrap, ctrl bit, varied tags, checked by model
        for (int i = 0; i < 48; i++) begin
            data_w = tok(((i % 4) == 3) ? 3'b000 : 3'((i % 7) + 1), i[0], DW'(i) * 32'h0101_0101);
            r_en   = ((i % 5) < 2) || (i > 40);
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_link_fifo.md
PE_LINK_FIFO -- requirements
Module: pe_link_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the token payload width.
REQ-002 SHALL have parameter TAG_W, default 3, meaning the valid-tag width; the token is {tag, ctrl, payload} with width TAG_W+1+DATA_W (36 by default).
REQ-003 SHALL have parameter DEPTH, default 8, meaning the token storage depth; it SHALL be a power of 2 and at least 2.
REQ-004 SHALL have parameter AF_MARGIN, default 1, meaning the free slots reserved for in-flight tokens; legal range 0 to DEPTH-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port data_w, input, TAG_W+1+DATA_W bits: the upstream token; tag != 0 marks it valid.
REQ-008 SHALL have port flush, input, 1 bit: synchronous clear of all stored tokens.
REQ-009 SHALL have port r_en, input, 1 bit: the downstream-ready signal; high means downstream can take the head token.
REQ-010 SHALL have port data_r, output, TAG_W+1+DATA_W bits: the head token; tag forced to 0 when empty.
REQ-011 SHALL have port bp, output, 1 bit: upstream-ready; high means space is available.
REQ-012 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have port ovf, output, 1 bit: sticky overflow flag.

Function
REQ-014 SHALL accept a write on a rising edge when data_w tag != 0, storing the full token unmodified, including the ctrl bit and payload.
REQ-015 SHALL present the head token on data_r combinationally from registered storage (first-word-fall-through); a token written into an empty FIFO at edge N SHALL appear at data_r after edge N.
REQ-016 SHALL pop the head token on a rising edge when r_en=1 and count>0; r_en while empty has no effect.
REQ-017 SHALL drive bp = 1 when (DEPTH - count) > AF_MARGIN, and 0 otherwise, decoded combinationally from registered count.
REQ-018 SHALL, on a valid write while count=DEPTH and no pop occurs in the same cycle, drop the token, leave storage unchanged and set ovf=1; ovf SHALL stay set until reset or flush.
REQ-019 SHALL, on a simultaneous valid write and pop while full, accept the write with count unchanged and ovf not set.
REQ-020 SHALL, on a simultaneous valid write and pop while empty, ignore the pop; count becomes 1 and the token appears next cycle (no bypass).
REQ-021 SHALL wrap read and write pointers modulo DEPTH and derive full/empty from count only.
REQ-022 SHALL, when flush=1, set count=0, set both pointers to 0 and clear ovf at the edge; any write or pop in the same cycle is discarded.

Reset
REQ-023 SHALL, on rst_n=0, immediately clear pointers, count and ovf, giving data_r tag=0, bp=1 (for AF_MARGIN<DEPTH) and count=0, independent of clk.
REQ-024 SHALL, on reset asserted mid-transfer, lose all stored tokens; storage payload contents need not be cleared.
REQ-025 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, when macro PE_LINK_FIFO_OVF_CNT_EN is defined, add output ovf_cnt (8 bits) counting dropped tokens, saturating at 255 and cleared by reset and flush.
REQ-027 SHALL, when PE_LINK_FIFO_OVF_CNT_EN is undefined, omit ovf_cnt and its counter; all other behaviour is identical.

Structure
REQ-028 SHALL place the token field offsets, TAG_W/DATA_W defaults and a token-valid function in shared package pe_link_pkg.
REQ-029 SHALL be implemented as one module with no sub-modules; storage SHALL be a register array.

Verification
REQ-030 SHALL verify with DEPTH=4, AF_MARGIN=1: write tokens {3'b110,1'b0,32'd1..4} on consecutive cycles with r_en=0 -> bp falls after the 3rd write, count=4, ovf=0.
REQ-031 SHALL verify: with the FIFO full, write {3'b110,0,32'd5} with r_en=0 -> token dropped, ovf=1, ovf_cnt=1 when the macro is defined; drain with r_en=1 -> data_r shows 1,2,3,4 in order.
REQ-032 SHALL verify: with the FIFO full, write 32'd9 together with r_en=1 -> count stays 4, ovf stays 0, and 9 is drained last.
REQ-033 SHALL verify: with the FIFO empty, write 32'd7 together with r_en=1 -> data_r tag=110 and payload 7 on the next cycle, count=1.
REQ-034 SHALL verify: hold tag=0 tokens for 10 cycles -> count stays 0 and data_r tag=000.
REQ-035 SHALL verify: assert rst_n=0 asynchronously mid-cycle with count=3 -> count=0, bp=1 and data_r tag=0 before the next edge; flush with count=2 -> same result at the edge.
